// File: rtl/mem_fetch_ctrl_if.sv
// Memory request/response bus plus staging-buffer write port of the fetch controller.
interface mem_fetch_ctrl_if #(
    parameter int N              = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int BANKING_FACTOR = 1,
    parameter int ADDRESS_WIDTH  = 13
);
    localparam int BW = DATA_WIDTH * BANKING_FACTOR;
    localparam int IW = $clog2(N * N);

    logic                     mem_read_en;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr;
    logic                     mem_write_en;
    logic [BW-1:0]            mem_req_data;
    logic [BW-1:0]            mem_resp_data;
    logic                     buf_wr_en;
    logic                     buf_sel;
    logic [IW-1:0]            buf_wr_idx;
    logic [BW-1:0]            buf_wr_data;

    // Controller side: issues requests, consumes responses, writes the buffer.
    modport master (
        output mem_read_en, mem_req_addr, mem_write_en, mem_req_data,
        input  mem_resp_data,
        output buf_wr_en, buf_sel, buf_wr_idx, buf_wr_data
    );

    // Memory/buffer side.
    modport slave (
        input  mem_read_en, mem_req_addr, mem_write_en, mem_req_data,
        output mem_resp_data,
        input  buf_wr_en, buf_sel, buf_wr_idx, buf_wr_data
    );
endinterface

// File: rtl/mem_fetch_ctrl.sv
// Fetches the weight matrix then the X matrix, one beat per MEM_LATENCY+1
// cycles, and streams each returned beat into the staging buffer.
module mem_fetch_ctrl #(
    parameter int                     N              = 4,
    parameter int                     DATA_WIDTH     = 16,
    parameter int                     BANKING_FACTOR = 1,
    parameter int                     ADDRESS_WIDTH  = 13,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_W  = 13'h0000,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_X  = 13'h1000,
    parameter int                     MEM_LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    mem_fetch_ctrl_if.master bus
);
    localparam int BEATS = N * N / BANKING_FACTOR;
    localparam int STEP  = BANKING_FACTOR * DATA_WIDTH / 8;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LCW   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int IW    = $clog2(N * N);
    localparam logic [ADDRESS_WIDTH-1:0] STEP_A = ADDRESS_WIDTH'(STEP);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_DONE} state_t;

    state_t         state, state_nx;
    logic [BCW-1:0] beat, beat_nx;   // beat currently in flight within the matrix
    logic           sel, sel_nx;     // 0 = weights, 1 = X
    logic [LCW-1:0] lat, lat_nx;     // cycles spent in WAIT
    logic           rd_en, wr_en;
    logic           last_beat;

    assign last_beat = (beat == BCW'(BEATS - 1));

    // State and counter registers; async reset drops everything back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            beat  <= '0;
            sel   <= 1'b0;
            lat   <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            sel   <= sel_nx;
            lat   <= lat_nx;
        end
    end

    // Next-state logic and output decode. A CAPT cycle both retires the
    // current beat and requests the next one, so the request cadence equals
    // the responder's busy window.
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        sel_nx   = sel;
        lat_nx   = lat;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                beat_nx = '0;
                sel_nx  = 1'b0;
                lat_nx  = '0;
                if (start) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                rd_en    = 1'b1;
                lat_nx   = '0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (lat == LCW'(MEM_LATENCY - 1)) state_nx = S_CAPT;
                else                              lat_nx   = lat + 1'b1;
            end
            S_CAPT: begin
                wr_en  = 1'b1;
                lat_nx = '0;
                if (last_beat && sel) begin
                    state_nx = S_DONE;
                end else begin
                    rd_en    = 1'b1;
                    state_nx = S_WAIT;
                    if (last_beat) begin
                        sel_nx  = 1'b1;
                        beat_nx = '0;
                    end else begin
                        beat_nx = beat + 1'b1;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Request address always refers to the beat being asked for next
        // (beat_nx/sel_nx equal beat/sel in ISSUE). Wraps silently.
        bus.mem_read_en  = rd_en;
        bus.mem_req_addr = rd_en ? ((sel_nx ? BASE_ADDR_X : BASE_ADDR_W)
                                    + ADDRESS_WIDTH'(beat_nx) * STEP_A) : '0;
        bus.mem_write_en = 1'b0;
        bus.mem_req_data = '0;
        bus.buf_wr_en    = wr_en;
        bus.buf_sel      = wr_en & sel;
        bus.buf_wr_idx   = wr_en ? IW'(beat) * IW'(BANKING_FACTOR) : '0;
        bus.buf_wr_data  = wr_en ? bus.mem_resp_data : '0;
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
    end
endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed bench: three controller instances (LAT=2, LAT=1, BF=2), each fed
// by a small fixed-latency responder model.
module tb_mem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic busy0, busy1, busy2, done0, done1, done2;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_fetch_ctrl_if #(.N(4), .DATA_WIDTH(16), .BANKING_FACTOR(1), .ADDRESS_WIDTH(13)) b0();
    mem_fetch_ctrl_if #(.N(4), .DATA_WIDTH(16), .BANKING_FACTOR(1), .ADDRESS_WIDTH(13)) b1();
    mem_fetch_ctrl_if #(.N(4), .DATA_WIDTH(16), .BANKING_FACTOR(2), .ADDRESS_WIDTH(13)) b2();

    mem_fetch_ctrl #(.MEM_LATENCY(2)) u0 (.clk(clk), .rst(rst), .start(s0), .busy(busy0), .done(done0), .bus(b0));
    mem_fetch_ctrl #(.MEM_LATENCY(1)) u1 (.clk(clk), .rst(rst), .start(s1), .busy(busy1), .done(done1), .bus(b1));
    mem_fetch_ctrl #(.BANKING_FACTOR(2), .MEM_LATENCY(2)) u2 (.clk(clk), .rst(rst), .start(s2), .busy(busy2), .done(done2), .bus(b2));

    // Element at 16-bit word address w reads as {w[1:0], 7'b0, is_x} in the high/low bytes.
    function automatic logic [31:0] resp_of(input logic [12:0] a, input int bf);
        logic [31:0] r;
        logic [12:0] w;
        r = '0;
        for (int e = 0; e < bf; e++) begin
            w = (a >> 1) + 13'(e);
            r[e*16 +: 16] = {6'b0, w[1:0], 7'b0, a[12]};
        end
        return r;
    endfunction

    function automatic logic [12:0] beat_addr(input int b, input int beats, input int bf);
        return 13'(((b >= beats) ? 32'h1000 : 32'h0) + (b % beats) * 2 * bf);
    endfunction

    // Responder models: capture on read, present registered data MEM_LATENCY cycles later.
    logic [12:0] a0, a1, a2;
    int          c0, c1, c2;
    logic [15:0] r0, r1;
    logic [31:0] r2;
    assign b0.mem_resp_data = r0;
    assign b1.mem_resp_data = r1;
    assign b2.mem_resp_data = r2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin c0 <= 0; r0 <= '0; a0 <= '0; end
        else if (b0.mem_read_en) begin a0 <= b0.mem_req_addr; c0 <= 2; end
        else if (c0 > 0) begin c0 <= c0 - 1; if (c0 == 1) r0 <= 16'(resp_of(a0, 1)); end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin c1 <= 0; r1 <= '0; a1 <= '0; end
        else if (b1.mem_read_en) begin a1 <= b1.mem_req_addr; c1 <= 1; end
        else if (c1 > 0) begin c1 <= c1 - 1; if (c1 == 1) r1 <= 16'(resp_of(a1, 1)); end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin c2 <= 0; r2 <= '0; a2 <= '0; end
        else if (b2.mem_read_en) begin a2 <= b2.mem_req_addr; c2 <= 2; end
        else if (c2 > 0) begin c2 <= c2 - 1; if (c2 == 1) r2 <= resp_of(a2, 2); end
    end

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       s0 = v;
            1:       s1 = v;
            default: s2 = v;
        endcase
    endtask

    task automatic sample(input int w, output logic [3:0] ctl, output logic [12:0] addr,
                          output logic [3:0] idx, output logic sel, output logic [31:0] data);
        case (w)
            0: begin
                ctl = {busy0, done0, b0.mem_read_en, b0.buf_wr_en}; addr = b0.mem_req_addr;
                idx = b0.buf_wr_idx; sel = b0.buf_sel; data = {16'h0, b0.buf_wr_data};
            end
            1: begin
                ctl = {busy1, done1, b1.mem_read_en, b1.buf_wr_en}; addr = b1.mem_req_addr;
                idx = b1.buf_wr_idx; sel = b1.buf_sel; data = {16'h0, b1.buf_wr_data};
            end
            default: begin
                ctl = {busy2, done2, b2.mem_read_en, b2.buf_wr_en}; addr = b2.mem_req_addr;
                idx = b2.buf_wr_idx; sel = b2.buf_sel; data = b2.buf_wr_data;
            end
        endcase
    endtask

    // Raise start for one sampling edge; leaves us at the negedge of cycle 1.
    task automatic kick(input int w, input bit keep);
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        if (!keep) set_start(w, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Walk cycles 1..ncyc of a fetch, comparing every cycle against the timing formulas.
    task automatic run_check(input int w, input int lat, input int bf, input int ncyc,
                             input int pulse_at, input bit hold, input string tag);
        int beats, dcyc, rc, eb, cb;
        logic [3:0] ctl, ectl, idx, eidx;
        logic [12:0] addr, eaddr;
        logic sel, esel;
        logic [31:0] data, edata;
        beats = 16 / bf;
        dcyc  = 2 + 2 * beats * (lat + 1);
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            rc = (hold && cyc >= dcyc + 2) ? cyc - (dcyc + 1) : cyc;
            ectl = 4'b0; eaddr = '0; eidx = '0; esel = 1'b0; edata = '0;
            if (!((hold && cyc == dcyc + 1) || (!hold && cyc > dcyc))) begin
                ectl[3] = 1'b1;
                if (rc == dcyc) ectl[2] = 1'b1;
                if (rc < dcyc && (rc - 1) % (lat + 1) == 0) begin
                    eb = (rc - 1) / (lat + 1);
                    if (eb < 2 * beats) begin ectl[1] = 1'b1; eaddr = beat_addr(eb, beats, bf); end
                    if (rc > 1) begin
                        cb = eb - 1;
                        ectl[0] = 1'b1;
                        eidx  = 4'((cb % beats) * bf);
                        esel  = (cb >= beats);
                        edata = resp_of(beat_addr(cb, beats, bf), bf);
                    end
                end
            end
            sample(w, ctl, addr, idx, sel, data);
            total++;
            if (ctl !== ectl) $display("FAIL %s cyc %0d ctl{busy,done,rd,wr} got %b want %b", tag, cyc, ctl, ectl);
            else passed++;
            if (ectl[1]) begin
                total++;
                if (addr !== eaddr) $display("FAIL %s cyc %0d addr got %h want %h", tag, cyc, addr, eaddr);
                else passed++;
            end
            if (ectl[0]) begin
                total++;
                if ({sel, idx, data} !== {esel, eidx, edata})
                    $display("FAIL %s cyc %0d sel/idx/data got %b/%0d/%h want %b/%0d/%h",
                             tag, cyc, sel, idx, data, esel, eidx, edata);
                else passed++;
            end
            if (cyc == pulse_at)     set_start(w, 1'b1);
            if (cyc == pulse_at + 1) set_start(w, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int act;
        kick(0, 1'b0);
        repeat (3) @(negedge clk);   // cycle 4: first CAPT, outputs active
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy0, done0, b0.mem_read_en, b0.buf_wr_en, b0.mem_write_en, b0.mem_req_addr,
             b0.mem_req_data, b0.buf_sel, b0.buf_wr_idx, b0.buf_wr_data} !== '0)
            $display("FAIL reset_async outputs got busy=%b wr=%b want all 0", busy0, b0.buf_wr_en);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b0.mem_read_en || busy0) act++;
        end
        total++;
        if (act !== 0) $display("FAIL reset_idle active cycles got %0d want 0", act);
        else passed++;
    endtask

    task automatic test_full_fetch();
        kick(0, 1'b0);
        run_check(0, 2, 1, 100, -10, 1'b0, "full_fetch");
    endtask

    task automatic test_lat1();
        kick(1, 1'b0);
        run_check(1, 1, 1, 68, -10, 1'b0, "lat1");
    endtask

    task automatic test_banking();
        kick(2, 1'b0);
        run_check(2, 2, 2, 52, -10, 1'b0, "banking");
    endtask

    task automatic test_start_pulse();
        kick(0, 1'b0);
        run_check(0, 2, 1, 100, 10, 1'b0, "start_pulse");
    endtask

    task automatic test_back_to_back();
        kick(0, 1'b1);
        run_check(0, 2, 1, 101, -10, 1'b1, "back_to_back");
        s0 = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        int act;
        kick(0, 1'b0);
        repeat (16) @(negedge clk);  // cycle 17: WAIT of beat 5
        #1 rst = 1'b1;
        #1;
        total++;
        if ({busy0, done0, b0.mem_read_en, b0.buf_wr_en} !== 4'b0)
            $display("FAIL reset_mid outputs got %b want 0000", {busy0, done0, b0.mem_read_en, b0.buf_wr_en});
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b0.buf_wr_en || done0 || b0.mem_read_en) act++;
        end
        total++;
        if (act !== 0) $display("FAIL reset_mid_quiet active cycles got %0d want 0", act);
        else passed++;
        kick(0, 1'b0);
        run_check(0, 2, 1, 12, -10, 1'b0, "restart");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_full_fetch();
        test_lat1();
        test_banking();
        test_start_pulse();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
